// File: rtl/updown_counter_mod.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_mod
// Description : Up/down counter with programmable step, inclusive upper bound,
//               wrap or saturate mode, terminal-count pulse and sticky flags.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_mod #(
    parameter int WIDTH     = 8,
    parameter int STEP_W    = 4,
    parameter int RESET_VAL = 0,
    parameter int SATURATE  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              load,
    input  logic              enable,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  max_val,
    input  logic              clear_flags,
    output logic [WIDTH-1:0]  data_out,
    output logic              tc,
    output logic              load_err,
    output logic              ovf_sticky,
    output logic              unf_sticky
);

    localparam logic [WIDTH-1:0] c_RESET_VAL = WIDTH'(RESET_VAL);
    localparam logic [WIDTH:0]   c_ONE_X     = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_load_err;
    logic             r_ovf;
    logic             r_unf;

    // Boundary arithmetic is carried in WIDTH+1 bits so max_val = 2^WIDTH-1 cannot overflow.
    logic [WIDTH:0]   w_cnt_x;
    logic [WIDTH:0]   w_max_x;
    logic [WIDTH:0]   w_step_x;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_up_wrap;
    logic [WIDTH:0]   w_dn_wrap;
    logic [WIDTH-1:0] w_diff;

    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tc_nxt;
    logic             w_load_err_nxt;
    logic             w_set_ovf;
    logic             w_set_unf;

    assign w_cnt_x   = {1'b0, r_count};
    assign w_max_x   = {1'b0, max_val};
    assign w_step_x  = (WIDTH + 1)'(step);
    assign w_sum     = w_cnt_x + w_step_x;
    assign w_up_wrap = w_sum - w_max_x - c_ONE_X;
    assign w_dn_wrap = w_cnt_x + w_max_x + c_ONE_X - w_step_x;
    assign w_diff    = r_count - WIDTH'(step);

    always_comb begin
        w_count_nxt    = r_count;
        w_tc_nxt       = 1'b0;
        w_load_err_nxt = 1'b0;
        w_set_ovf      = 1'b0;
        w_set_unf      = 1'b0;
        if (load) begin
            if (data_in <= max_val) begin
                w_count_nxt = data_in;
            end else begin
                w_count_nxt    = max_val;
                w_load_err_nxt = 1'b1;
            end
        end else if (enable) begin
            if (r_count > max_val) begin
                // Bound was lowered beneath the count: pull back in silently.
                w_count_nxt = max_val;
            end else if (step == '0) begin
                w_count_nxt = r_count;
            end else if (up_down) begin
                if (w_sum <= w_max_x) begin
                    w_count_nxt = w_sum[WIDTH-1:0];
                end else begin
                    w_tc_nxt  = 1'b1;
                    w_set_ovf = 1'b1;
                    if (SATURATE != 0)
                        w_count_nxt = max_val;
                    else if (w_up_wrap > w_max_x)
                        w_count_nxt = max_val;
                    else
                        w_count_nxt = w_up_wrap[WIDTH-1:0];
                end
            end else begin
                if (w_cnt_x >= w_step_x) begin
                    w_count_nxt = w_diff;
                end else begin
                    w_tc_nxt  = 1'b1;
                    w_set_unf = 1'b1;
                    if (SATURATE != 0)
                        w_count_nxt = '0;
                    else if (w_dn_wrap > w_max_x)
                        w_count_nxt = max_val;
                    else
                        w_count_nxt = w_dn_wrap[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count    <= c_RESET_VAL;
            r_tc       <= 1'b0;
            r_load_err <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_tc       <= w_tc_nxt;
            r_load_err <= w_load_err_nxt;
            // A set event on the same edge as clear_flags wins.
            r_ovf      <= (r_ovf & ~clear_flags) | w_set_ovf;
            r_unf      <= (r_unf & ~clear_flags) | w_set_unf;
        end
    end

    assign data_out   = r_count;
    assign tc         = r_tc;
    assign load_err   = r_load_err;
    assign ovf_sticky = r_ovf;
    assign unf_sticky = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_mod.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_counter_mod
// Description : Self-checking bench: directed vector table, saturate sequence,
//               and randomized run against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_counter_mod;

    localparam int c_W = 8;
    localparam int c_SW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [c_W-1:0]  data_in = '0;
    logic            load = 1'b0;
    logic            enable = 1'b0;
    logic            up_down = 1'b0;
    logic [c_SW-1:0] step = '0;
    logic [c_W-1:0]  max_val = '0;
    logic            clear_flags = 1'b0;

    logic [c_W-1:0]  w_dout_w, w_dout_s;
    logic            w_tc_w, w_tc_s, w_lerr_w, w_lerr_s;
    logic            w_ovf_w, w_ovf_s, w_unf_w, w_unf_s;

    int total = 0;
    int bad = 0;

    updown_counter_mod #(.WIDTH(c_W), .STEP_W(c_SW), .RESET_VAL(0), .SATURATE(0)) u_dut_wrap (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load), .enable(enable),
        .up_down(up_down), .step(step), .max_val(max_val), .clear_flags(clear_flags),
        .data_out(w_dout_w), .tc(w_tc_w), .load_err(w_lerr_w),
        .ovf_sticky(w_ovf_w), .unf_sticky(w_unf_w)
    );

    updown_counter_mod #(.WIDTH(c_W), .STEP_W(c_SW), .RESET_VAL(0), .SATURATE(1)) u_dut_sat (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load), .enable(enable),
        .up_down(up_down), .step(step), .max_val(max_val), .clear_flags(clear_flags),
        .data_out(w_dout_s), .tc(w_tc_s), .load_err(w_lerr_s),
        .ovf_sticky(w_ovf_s), .unf_sticky(w_unf_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst_n;
        bit       ld;
        bit       en;
        bit       up;
        int       stp;
        int       din;
        int       mx;
        bit       clr;
        int       e_cnt;
        bit       e_tc;
        bit       e_lerr;
        bit       e_ovf;
        bit       e_unf;
    } vec_t;

    typedef struct {
        int cnt;
        bit tc;
        bit lerr;
        bit ovf;
        bit unf;
    } mst_t;

    // Next-state reference computed straight from the counting rules with integers.
    function automatic mst_t model(mst_t s, bit sat, bit rst_n, bit ld, bit en, bit up,
                                   int stp, int din, int mx, bit clr);
        mst_t n;
        bit so, su;
        int r;
        n = s;
        n.tc = 0;
        n.lerr = 0;
        so = 0;
        su = 0;
        if (!rst_n) begin
            n.cnt = 0; n.ovf = 0; n.unf = 0;
            return n;
        end
        if (ld) begin
            if (din <= mx) n.cnt = din;
            else begin n.cnt = mx; n.lerr = 1; end
        end else if (en) begin
            if (s.cnt > mx) n.cnt = mx;
            else if (stp == 0) n.cnt = s.cnt;
            else if (up) begin
                if (s.cnt + stp <= mx) n.cnt = s.cnt + stp;
                else begin
                    n.tc = 1; so = 1;
                    r = s.cnt + stp - (mx + 1);
                    n.cnt = sat ? mx : ((r > mx) ? mx : r);
                end
            end else begin
                if (s.cnt >= stp) n.cnt = s.cnt - stp;
                else begin
                    n.tc = 1; su = 1;
                    r = (((s.cnt + mx + 1 - stp) % 512) + 512) % 512;
                    n.cnt = sat ? 0 : ((r > mx) ? mx : r);
                end
            end
        end
        n.ovf = (s.ovf && !clr) || so;
        n.unf = (s.unf && !clr) || su;
        return n;
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got cnt=%0d tc=%0b lerr=%0b ovf=%0b unf=%0b, want cnt=%0d tc=%0b lerr=%0b ovf=%0b unf=%0b",
                     name, act[11:4], act[3], act[2], act[1], act[0],
                     exp[11:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input bit rst_n, input bit ld, input bit en, input bit up,
                         input int stp, input int din, input int mx, input bit clr);
        reset = rst_n;
        load = ld;
        enable = en;
        up_down = up;
        step = c_SW'(stp);
        data_in = c_W'(din);
        max_val = c_W'(mx);
        clear_flags = clr;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] pack(int cnt, bit t, bit l, bit o, bit u);
        return {c_W'(cnt), t, l, o, u};
    endfunction

    vec_t vecs[$];

    initial begin
        mst_t mw, ms;

        // rst ld en up stp din mx clr | cnt tc lerr ovf unf
        vecs.push_back('{1,0,1,1, 3,  0,  9,0,  3,0,0,0,0});
        vecs.push_back('{1,0,1,1, 3,  0,  9,0,  6,0,0,0,0});
        vecs.push_back('{1,0,1,1, 3,  0,  9,0,  9,0,0,0,0});
        vecs.push_back('{1,0,1,1, 3,  0,  9,0,  2,1,0,1,0});
        vecs.push_back('{1,0,0,1, 3,  0,  9,0,  2,0,0,1,0});
        vecs.push_back('{1,1,0,0, 0, 50, 40,0, 40,0,1,1,0});
        vecs.push_back('{1,1,1,1, 3,  5, 40,0,  5,0,0,1,0});
        vecs.push_back('{1,1,0,0, 0, 30, 40,0, 30,0,0,1,0});
        vecs.push_back('{1,0,1,1, 1,  0, 20,0, 20,0,0,1,0});
        vecs.push_back('{1,0,1,1, 1,  0, 20,0,  0,1,0,1,0});
        vecs.push_back('{1,0,0,0, 0,  0, 20,1,  0,0,0,0,0});
        vecs.push_back('{1,1,0,0, 0, 19, 20,0, 19,0,0,0,0});
        vecs.push_back('{1,0,1,1, 3,  0, 20,1,  1,1,0,1,0});
        vecs.push_back('{1,0,0,0, 0,  0, 20,1,  1,0,0,0,0});
        vecs.push_back('{1,0,1,0, 4,  0, 20,0, 18,1,0,0,1});
        vecs.push_back('{1,0,1,0, 0,  0, 20,0, 18,0,0,0,1});
        vecs.push_back('{1,0,1,0, 2,  0, 20,0, 16,0,0,0,1});
        vecs.push_back('{1,1,0,0, 0,  4, 20,0,  4,0,0,0,1});
        vecs.push_back('{1,0,1,0, 4,  0, 20,0,  0,0,0,0,1});
        vecs.push_back('{1,1,0,0, 0, 17, 20,0, 17,0,0,0,1});
        vecs.push_back('{1,0,1,1, 3,  0, 20,0, 20,0,0,0,1});
        vecs.push_back('{1,1,0,0, 0,  5,  5,0,  5,0,0,0,1});
        vecs.push_back('{1,0,1,1,15,  0,  5,0,  5,1,0,1,1});
        vecs.push_back('{1,1,0,0, 0,  0,  5,1,  0,0,0,0,0});
        vecs.push_back('{1,0,1,0,15,  0,  5,0,  5,1,0,0,1});
        vecs.push_back('{1,1,0,0, 0,250,255,0,250,0,0,0,1});
        vecs.push_back('{1,0,1,1,10,  0,255,0,  4,1,0,1,1});
        vecs.push_back('{1,0,1,1, 1,  0,255,0,  5,0,0,1,1});
        vecs.push_back('{0,0,1,1, 1,  0,255,0,  0,0,0,0,0});

        // Reset held for two edges, then released.
        drive(0, 0, 0, 0, 0, 0, 9, 0);
        tick();
        tick();
        chk("reset_wrap", {w_dout_w, w_tc_w, w_lerr_w, w_ovf_w, w_unf_w}, pack(0, 0, 0, 0, 0));
        chk("reset_sat", {w_dout_s, w_tc_s, w_lerr_s, w_ovf_s, w_unf_s}, pack(0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].ld, vecs[i].en, vecs[i].up,
                  vecs[i].stp, vecs[i].din, vecs[i].mx, vecs[i].clr);
            tick();
            chk($sformatf("vec%0d", i), {w_dout_w, w_tc_w, w_lerr_w, w_ovf_w, w_unf_w},
                pack(vecs[i].e_cnt, vecs[i].e_tc, vecs[i].e_lerr, vecs[i].e_ovf, vecs[i].e_unf));
        end

        // Saturating instance: clamp at the top, then clamp at zero.
        drive(1, 1, 0, 1, 0, 198, 200, 0);
        tick();
        chk("sat_load", {w_dout_s, w_tc_s, w_lerr_s, w_ovf_s, w_unf_s}, pack(198, 0, 0, 0, 0));
        drive(1, 0, 1, 1, 5, 0, 200, 0);
        tick();
        chk("sat_up1", {w_dout_s, w_tc_s, w_lerr_s, w_ovf_s, w_unf_s}, pack(200, 1, 0, 1, 0));
        tick();
        chk("sat_up2", {w_dout_s, w_tc_s, w_lerr_s, w_ovf_s, w_unf_s}, pack(200, 1, 0, 1, 0));
        drive(1, 1, 0, 0, 0, 5, 200, 0);
        tick();
        chk("sat_load5", {w_dout_s, w_tc_s, w_lerr_s, w_ovf_s, w_unf_s}, pack(5, 0, 0, 1, 0));
        drive(1, 0, 1, 0, 7, 0, 200, 0);
        tick();
        chk("sat_down", {w_dout_s, w_tc_s, w_lerr_s, w_ovf_s, w_unf_s}, pack(0, 1, 0, 1, 1));
        drive(1, 0, 1, 0, 0, 0, 200, 0);
        tick();
        chk("sat_hold0", {w_dout_s, w_tc_s, w_lerr_s, w_ovf_s, w_unf_s}, pack(0, 0, 0, 1, 1));

        // Randomized run, both modes against the reference model.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        mw = '{0, 0, 0, 0, 0};
        ms = '{0, 0, 0, 0, 0};
        for (int k = 0; k < 600; k++) begin
            bit rn, ld, en, up, clr;
            int stp, din, mx;
            rn  = ($urandom_range(0, 49) != 0);
            ld  = ($urandom_range(0, 7) == 0);
            en  = ($urandom_range(0, 3) != 0);
            up  = $urandom_range(0, 1) != 0;
            stp = $urandom_range(0, 15);
            clr = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: mx = 255;
                1: mx = $urandom_range(0, 15);
                default: mx = $urandom_range(0, 255);
            endcase
            din = $urandom_range(0, 255);
            drive(rn, ld, en, up, stp, din, mx, clr);
            mw = model(mw, 0, rn, ld, en, up, stp, din, mx, clr);
            ms = model(ms, 1, rn, ld, en, up, stp, din, mx, clr);
            tick();
            chk($sformatf("rand_wrap%0d", k), {w_dout_w, w_tc_w, w_lerr_w, w_ovf_w, w_unf_w},
                pack(mw.cnt, mw.tc, mw.lerr, mw.ovf, mw.unf));
            chk($sformatf("rand_sat%0d", k), {w_dout_s, w_tc_s, w_lerr_s, w_ovf_s, w_unf_s},
                pack(ms.cnt, ms.tc, ms.lerr, ms.ovf, ms.unf));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
